// File: rtl/instruction_fetch_decode.sv
// rtl/instruction_fetch_decode.sv - fetch/decode front end with req/ack fetch, stall and redirect
module instruction_fetch_decode #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        pc_load,
  input  logic [31:0] pc_target,
  output logic        inst_valid,
  output logic [31:0] pc,
  output logic [2:0]  i_type,
  output logic [16:0] instruction,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic [31:0] imm,
  output logic        illegal
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD, DRAIN} state_t;

  state_t      state, state_nx;
  logic [31:0] pc_nx, drain_addr, drain_addr_nx, target;
  logic        capture;

  logic [6:0]  op;
  logic [2:0]  f3;
  logic [2:0]  dec_type;
  logic [16:0] dec_key;
  logic [31:0] dec_imm;
  logic        dec_illegal, keep_f7, keep_f3;

  assign target     = pc_target & ~32'd3;
  assign imem_req   = (state == REQ) || (state == DRAIN);
  // DRAIN keeps presenting the abandoned address while pc already holds the redirect
  assign imem_addr  = (state == DRAIN) ? drain_addr : pc;
  assign inst_valid = (state == HOLD);

  always_comb begin
    state_nx      = state;
    pc_nx         = pc;
    drain_addr_nx = drain_addr;
    capture       = 1'b0;
    case (state)
      IDLE: begin
        state_nx = REQ;
        if (pc_load) pc_nx = target;
      end
      REQ: begin
        if (pc_load) begin
          pc_nx = target;
          if (!imem_ack) begin
            drain_addr_nx = pc;
            state_nx      = DRAIN;
          end
        end else if (imem_ack) begin
          capture  = 1'b1;
          state_nx = HOLD;
        end
      end
      HOLD: begin
        if (pc_load) begin
          pc_nx    = target;
          state_nx = REQ;
        end else if (!stall) begin
          pc_nx    = pc + 32'd4;
          state_nx = REQ;
        end
      end
      DRAIN: begin
        if (pc_load) pc_nx = target;
        else if (imem_ack) state_nx = REQ;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign op = imem_rdata[6:0];
  assign f3 = imem_rdata[14:12];

  always_comb begin
    dec_type    = 3'd7;
    dec_illegal = 1'b0;
    dec_imm     = 32'd0;
    keep_f7     = 1'b0;
    keep_f3     = 1'b1;
    case (op)
      7'b0110011: begin
        dec_type = 3'd0;
        keep_f7  = 1'b1;
      end
      7'b0010011: begin
        dec_type = 3'd1;
        dec_imm  = {{20{imem_rdata[31]}}, imem_rdata[31:20]};
        keep_f7  = (f3 == 3'b001) || (f3 == 3'b101);
      end
      7'b0000011, 7'b1100111: begin
        dec_type = 3'd1;
        dec_imm  = {{20{imem_rdata[31]}}, imem_rdata[31:20]};
      end
      7'b0100011: begin
        dec_type = 3'd2;
        dec_imm  = {{20{imem_rdata[31]}}, imem_rdata[31:25], imem_rdata[11:7]};
      end
      7'b1100011: begin
        dec_type = 3'd3;
        dec_imm  = {{19{imem_rdata[31]}}, imem_rdata[31], imem_rdata[7],
                    imem_rdata[30:25], imem_rdata[11:8], 1'b0};
      end
      7'b1101111: begin
        dec_type = 3'd4;
        keep_f3  = 1'b0;
        dec_imm  = {{11{imem_rdata[31]}}, imem_rdata[31], imem_rdata[19:12],
                    imem_rdata[20], imem_rdata[30:21], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        dec_type = 3'd5;
        keep_f3  = 1'b0;
        dec_imm  = {imem_rdata[31:12], 12'd0};
      end
      default: dec_illegal = 1'b1;
    endcase
    dec_key = dec_illegal ? 17'd0 :
              {(keep_f7 ? imem_rdata[31:25] : 7'd0), (keep_f3 ? f3 : 3'd0), op};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      drain_addr <= RESET_PC;
    end else begin
      state      <= state_nx;
      pc         <= pc_nx;
      drain_addr <= drain_addr_nx;
    end
  end

  // Decoded fields only move on a clean capture, so they survive stall and drains
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_type      <= 3'd0;
      instruction <= 17'd0;
      rs1         <= 5'd0;
      rs2         <= 5'd0;
      rd          <= 5'd0;
      imm         <= 32'd0;
      illegal     <= 1'b0;
    end else if (capture) begin
      i_type      <= dec_type;
      instruction <= dec_key;
      rs1         <= imem_rdata[19:15];
      rs2         <= imem_rdata[24:20];
      rd          <= imem_rdata[11:7];
      imm         <= dec_imm;
      illegal     <= dec_illegal;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_decode.sv
// tb/tb_instruction_fetch_decode.sv - directed and randomized checks of instruction_fetch_decode
module tb_instruction_fetch_decode;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic        stall = 1'b0;
  logic        pc_load = 1'b0;
  logic [31:0] pc_target = 32'd0;
  logic        inst_valid;
  logic [31:0] pc;
  logic [2:0]  i_type;
  logic [16:0] instruction;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] imm;
  logic        illegal;

  int tests = 0;
  int fails = 0;
  logic [31:0] mpc;

  instruction_fetch_decode #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall),
    .pc_load(pc_load), .pc_target(pc_target), .inst_valid(inst_valid),
    .pc(pc), .i_type(i_type), .instruction(instruction), .rs1(rs1),
    .rs2(rs2), .rd(rd), .imm(imm), .illegal(illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference decode built from the opcode table with signed arithmetic
  task automatic ref_decode(input logic [31:0] w, output logic [2:0] t,
                            output logic [16:0] k, output logic [31:0] im, output logic il);
    logic [6:0]  o;
    logic [31:0] s7, f3v;
    int          sw;
    bit          f7_ok, f3_ok;
    o = w[6:0];
    sw = int'(w);
    f3v = {29'd0, w[14:12]};
    il = 1'b0; im = 32'd0; f7_ok = 1'b0; f3_ok = 1'b1;
    if (o == 7'h33) begin t = 3'd0; f7_ok = 1'b1; end
    else if (o == 7'h13 || o == 7'h03 || o == 7'h67) begin
      t = 3'd1; im = 32'(sw >>> 20);
      f7_ok = (o == 7'h13) && (f3v == 1 || f3v == 5);
    end
    else if (o == 7'h23) begin
      t = 3'd2; im = 32'((sw >>> 25) * 32) + {27'd0, w[11:7]};
    end
    else if (o == 7'h63) begin
      t = 3'd3;
      im = 32'((sw >>> 31) * 4096) + 32'(w[7]) * 2048 + 32'(w[30:25]) * 32 + 32'(w[11:8]) * 2;
    end
    else if (o == 7'h6F) begin
      t = 3'd4; f3_ok = 1'b0;
      im = 32'((sw >>> 31) * 1048576) + 32'(w[19:12]) * 4096 + 32'(w[20]) * 2048 + 32'(w[30:21]) * 2;
    end
    else if (o == 7'h37 || o == 7'h17) begin
      t = 3'd5; f3_ok = 1'b0; im = w & 32'hFFFF_F000;
    end
    else begin t = 3'd7; il = 1'b1; end
    s7 = f7_ok ? {25'd0, w[31:25]} : 32'd0;
    k = il ? 17'd0 : 17'(s7 * 1024 + (f3_ok ? f3v : 32'd0) * 128 + 32'(o));
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (imem_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {31'd0, imem_req}, 32'd1);
  endtask

  task automatic fetch(input logic [31:0] w, input int dly);
    logic [2:0]  t;
    logic [16:0] k;
    logic [31:0] im;
    logic        il;
    wait_req("req_timeout");
    chk("fetch_addr", imem_addr, mpc);
    for (int i = 0; i < dly; i++) begin
      @(negedge clk);
      chk("addr_stable", imem_addr, mpc);
      chk("req_held", {31'd0, imem_req}, 32'd1);
      chk("no_valid_wait", {31'd0, inst_valid}, 32'd0);
    end
    imem_ack = 1'b1;
    imem_rdata = w;
    @(negedge clk);
    imem_ack = 1'b0;
    imem_rdata = $urandom;
    ref_decode(w, t, k, im, il);
    chk("inst_valid", {31'd0, inst_valid}, 32'd1);
    chk("req_drop", {31'd0, imem_req}, 32'd0);
    chk("pc", pc, mpc);
    chk("i_type", {29'd0, i_type}, {29'd0, t});
    chk("key", {15'd0, instruction}, {15'd0, k});
    chk("imm", imm, im);
    chk("illegal", {31'd0, illegal}, {31'd0, il});
    chk("rs1", {27'd0, rs1}, {27'd0, w[19:15]});
    chk("rs2", {27'd0, rs2}, {27'd0, w[24:20]});
    chk("rd", {27'd0, rd}, {27'd0, w[11:7]});
  endtask

  function automatic logic [31:0] rand_word();
    logic [6:0]  ops [10];
    logic [31:0] r;
    ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h6F, 7'h37, 7'h17, 7'h00};
    r = $urandom;
    ops[9] = r[6:0];
    r = $urandom;
    return {r[31:7], ops[$urandom_range(0, 9)]};
  endfunction

  initial begin
    logic [31:0] save_pc, old_addr, tgt;
    logic [16:0] save_key;
    int          k;

    // Reset state
    @(negedge clk);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_pc", pc, 32'd0);
    chk("rst_itype", {29'd0, i_type}, 32'd0);
    chk("rst_key", {15'd0, instruction}, 32'd0);
    chk("rst_imm", imm, 32'd0);
    chk("rst_illegal", {31'd0, illegal}, 32'd0);
    rst = 1'b0;
    mpc = 32'd0;

    // Basic R-type
    fetch(32'h002081B3, 0);
    chk("t1_key", {15'd0, instruction}, 32'h33);
    chk("t1_rs1", {27'd0, rs1}, 32'd1);
    chk("t1_rs2", {27'd0, rs2}, 32'd2);
    chk("t1_rd", {27'd0, rd}, 32'd3);

    // SUB and ADDI -1
    mpc += 4;
    fetch(32'h40208133, 1);
    chk("t2_sub_key", {15'd0, instruction}, 32'h8033);
    chk("t2_sub_rd", {27'd0, rd}, 32'd2);
    mpc += 4;
    fetch(32'hFFF00293, 2);
    chk("t2_addi_type", {29'd0, i_type}, 32'd1);
    chk("t2_addi_imm", imm, 32'hFFFF_FFFF);
    chk("t2_addi_f7", {25'd0, instruction[16:10]}, 32'd0);

    // Stall in HOLD
    stall = 1'b1;
    save_pc = pc;
    save_key = instruction;
    repeat (3) begin
      @(negedge clk);
      chk("t3_valid", {31'd0, inst_valid}, 32'd1);
      chk("t3_req", {31'd0, imem_req}, 32'd0);
      chk("t3_pc", pc, save_pc);
      chk("t3_key", {15'd0, instruction}, {15'd0, save_key});
    end
    stall = 1'b0;
    mpc += 4;
    fetch(rand_word(), 0);

    // Redirect while waiting for ack: drain the old request
    mpc += 4;
    wait_req("t4_req_timeout");
    old_addr = imem_addr;
    chk("t4_addr", old_addr, mpc);
    save_key = instruction;
    pc_load = 1'b1;
    pc_target = 32'h103;
    @(negedge clk);
    pc_load = 1'b0;
    chk("t4_drain_req", {31'd0, imem_req}, 32'd1);
    chk("t4_drain_addr", imem_addr, old_addr);
    chk("t4_drain_valid", {31'd0, inst_valid}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    imem_ack = 1'b1;
    imem_rdata = 32'h0000007F;
    @(negedge clk);
    imem_ack = 1'b0;
    chk("t4_dropped_valid", {31'd0, inst_valid}, 32'd0);
    chk("t4_new_req", {31'd0, imem_req}, 32'd1);
    chk("t4_new_addr", imem_addr, 32'h100);
    chk("t4_key_kept", {15'd0, instruction}, {15'd0, save_key});
    mpc = 32'h100;

    // Illegal opcode and negative branch
    fetch(32'h0000007F, 0);
    chk("t5_illegal", {31'd0, illegal}, 32'd1);
    chk("t5_ill_type", {29'd0, i_type}, 32'd7);
    chk("t5_ill_imm", imm, 32'd0);
    mpc += 4;
    fetch(32'hFE000EE3, 1);
    chk("t5_beq_type", {29'd0, i_type}, 32'd3);
    chk("t5_beq_imm", imm, 32'hFFFF_FFFC);

    // Redirect from HOLD to the top of memory, then wrap
    pc_load = 1'b1;
    pc_target = 32'hFFFF_FFFF;
    @(negedge clk);
    pc_load = 1'b0;
    chk("wrap_valid_drop", {31'd0, inst_valid}, 32'd0);
    mpc = 32'hFFFF_FFFC;
    fetch(rand_word(), 0);
    mpc += 4;
    fetch(rand_word(), 1);
    chk("wrap_pc_zero", pc, 32'd0);

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: begin
          tgt = $urandom;
          pc_load = 1'b1;
          pc_target = tgt;
          stall = 1'($urandom_range(0, 1));
          @(negedge clk);
          pc_load = 1'b0;
          stall = 1'b0;
          chk("rnd_redir_valid", {31'd0, inst_valid}, 32'd0);
          mpc = {tgt[31:2], 2'b00};
        end
        1: begin
          k = $urandom_range(1, 3);
          save_pc = pc;
          stall = 1'b1;
          repeat (k) begin
            @(negedge clk);
            chk("rnd_stall_valid", {31'd0, inst_valid}, 32'd1);
            chk("rnd_stall_pc", pc, save_pc);
          end
          stall = 1'b0;
          mpc += 4;
        end
        default: mpc += 4;
      endcase
      fetch(rand_word(), $urandom_range(0, 3));
    end

    // Asynchronous reset during a pending request
    mpc += 4;
    wait_req("t6_req_timeout");
    #2 rst = 1'b1;
    #1;
    chk("t6_req_async", {31'd0, imem_req}, 32'd0);
    chk("t6_valid_async", {31'd0, inst_valid}, 32'd0);
    chk("t6_pc_async", pc, 32'd0);
    chk("t6_key_async", {15'd0, instruction}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    mpc = 32'd0;
    fetch(32'h002081B3, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
